pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It owns a register-write scoreboard covering x1–x31 and generates hold and flush controls for the PC, if_id and id_ex stages. It stalls the decode stage on read-after-write hazards and on multi-cycle execute operations. It also squashes wrong-path instructions on a taken jump and watches for stall deadlock. It sits beside decode/execute/writeback and drives the stage registers' hold/flush inputs.

## Interface
- `MAX_STALL`, 255: consecutive stall cycles before `deadlock_o` asserts (1..65535).
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous reset, active-low.
- `id_valid_i` in 1: decode holds a real instruction.
- `id_rs1_addr_i` / `id_rs2_addr_i` in 5: source registers from decode.
- `id_rs1_ren_i` / `id_rs2_ren_i` in 1: source actually read (ADDI: rs1 only; R-type: both).
- `id_rd_addr_i` in 5: destination from decode.
- `id_reg_wen_i` in 1: decode instruction writes back.
- `ex_jump_en_i` in 1: execute resolved a taken jump/branch this cycle.
- `ex_jump_addr_i` in 32: jump target.
- `ex_busy_i` in 1: execute is in a multi-cycle op and cannot accept.
- `wb_wen_i` in 1: writeback writes the regfile this cycle.
- `wb_rd_addr_i` in 5: writeback destination.
- `hold_pc_o` out 1: freeze PC.
- `hold_if_id_o` out 1: freeze if_id register.
- `flush_if_id_o` out 1: load bubble into if_id.
- `flush_id_ex_o` out 1: load bubble (reg_wen=0, rd=0) into id_ex.
- `jump_en_o` out 1, `jump_addr_o` out 32: PC redirect.
- `state_o` out 2: FSM state, for debug.
- `deadlock_o` out 1: sticky stall-timeout flag.

## Operation
- Scoreboard `pend[31:1]`; x0 is never pending and never hazards.
- Issue = `id_valid_i & !hold_if_id_o & !ex_jump_en_i`. On issue with `id_reg_wen_i` and rd≠0, set `pend[rd]` at the clock edge.
- `wb_wen_i` with rd≠0 clears `pend[wb_rd]`. If a set and a clear hit the same index in one cycle, the set wins.
- RAW hazard: `ren & pend[rs] & rs≠0 & !(wb_wen_i & wb_rd_addr_i==rs)`. A same-cycle writeback is not a hazard because the regfile is write-first.
- Priority: jump > busy > RAW.
  - Jump: `jump_en_o`=1, `flush_if_id_o`=1, `flush_id_ex_o`=1, no holds.
  - Busy: `hold_pc_o`=`hold_if_id_o`=1. No flush of id_ex, because execute holds its own register.
  - RAW: `hold_pc_o`=`hold_if_id_o`=1 and `flush_id_ex_o`=1 (bubble).
- FSM `state_o`: RUN=0, STALL_RAW=1, STALL_BUSY=2, FLUSH=3.
  - Next state follows the winning condition of the current cycle, or RUN if none.
  - FLUSH lasts exactly one cycle unless a jump repeats.
- Stall counter (16 b): increments each cycle next state is STALL_*. Resets to 0 on RUN or FLUSH.
- When the counter reaches `MAX_STALL`, `deadlock_o` sets and stays set until reset.

## Timing
- All hold, flush and jump outputs are combinational from current inputs and the registered `pend`, so they take effect the same cycle.
- `pend`, state, counter and `deadlock_o` update on the rising edge.
- Reset values: `pend`=0, state RUN, counter 0, `deadlock_o`=0, `jump_addr_o` = `ex_jump_addr_i` pass-through. All other outputs are 0 while `rst_n`=0.
- Asserting reset mid-stall clears all pending bits immediately. The first instruction after reset never stalls.
- A jump during a RAW stall flushes the stalled decode instruction without setting its `pend` bit.
- `jump_addr_o` is don't-care when `jump_en_o`=0.

## Structure
- Shared `defines` package: state encodings (`CTRL_RUN`, `CTRL_STALL_RAW`, `CTRL_STALL_BUSY`, `CTRL_FLUSH`) and the bubble constants `ZERO_REG`/`NOP_INST`, shared with decode.
- One natural sub-module, `scoreboard`: the 31-bit pend vector with set/clear/lookup ports.
- The FSM, priority logic and counter live in `pipe_ctrl`.

## Test plan
- Issue ADDI x5 (rd=5, wen) then R-type reading rs1=5 with no writeback → `hold_pc_o`=`hold_if_id_o`=`flush_id_ex_o`=1, `state_o`=1. Assert `wb_wen_i`, rd=5 → hazard drops the same cycle, RUN next.
- rs1=0 with `pend` all set, and rd=0 issues → never stalls, and `pend[0]` is never reported.
- `ex_jump_en_i`=1 with addr 0x8000_0010 while a RAW stall is active → jump 0x8000_0010, both flushes=1, no holds, FLUSH one cycle, stalled rd not set in `pend`.
- `ex_busy_i` for 4 cycles together with a RAW hazard → hold asserted, `flush_id_ex_o`=0, `state_o`=2 for 4 cycles, then RAW handling.
- `MAX_STALL`=8, RAW held for 10 cycles → `deadlock_o` rises after the 8th stall cycle and stays 1 after the hazard clears.
- Pull `rst_n` low asynchronously mid-stall → all outputs and `pend` go to 0 immediately, and a subsequent dependent instruction does not stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/sequencing controller.
// Decode uses the same bubble constants, so they live here and not in the
// controller itself.
//   ctrl_state_e : controller FSM encodings (also driven out on state_o)
//   ZERO_REG     : architectural x0, never pending and never a hazard
//   NOP_INST     : canonical bubble instruction (ADDI x0, x0, 0)
//   STALL_CNT_W  : width of the consecutive-stall counter
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    CTRL_RUN        = 2'd0,
    CTRL_STALL_RAW  = 2'd1,
    CTRL_STALL_BUSY = 2'd2,
    CTRL_FLUSH      = 2'd3
  } ctrl_state_e;

  localparam logic [4:0]  ZERO_REG    = 5'd0;
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;
  localparam int unsigned STALL_CNT_W = 16;

  // Both stall flavours count toward the deadlock timeout.
  function automatic logic is_stall(input ctrl_state_e s);
    return (s == CTRL_STALL_RAW) || (s == CTRL_STALL_BUSY);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_if
// Bundle of every signal exchanged between the pipeline stages and the
// hazard controller. Names keep the controller-side _i/_o suffixes.
//   master : pipeline side (drives decode/execute/writeback status,
//            receives hold/flush/redirect controls)
//   slave  : pipe_ctrl side
// ---------------------------------------------------------------------------
interface pipe_ctrl_if;

  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        id_rs1_ren_i;
  logic        id_rs2_ren_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_reg_wen_i;
  logic        ex_jump_en_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_busy_i;
  logic        wb_wen_i;
  logic [4:0]  wb_rd_addr_i;

  logic        hold_pc_o;
  logic        hold_if_id_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic [1:0]  state_o;
  logic        deadlock_o;

  modport master (
    output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_ren_i, id_rs2_ren_i,
           id_rd_addr_i, id_reg_wen_i, ex_jump_en_i, ex_jump_addr_i, ex_busy_i,
           wb_wen_i, wb_rd_addr_i,
    input  hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o, jump_en_o,
           jump_addr_o, state_o, deadlock_o
  );

  modport slave (
    input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_ren_i, id_rs2_ren_i,
           id_rd_addr_i, id_reg_wen_i, ex_jump_en_i, ex_jump_addr_i, ex_busy_i,
           wb_wen_i, wb_rd_addr_i,
    output hold_pc_o, hold_if_id_o, flush_if_id_o, flush_id_ex_o, jump_en_o,
           jump_addr_o, state_o, deadlock_o
  );

endinterface

// File: rtl/pipe_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_scoreboard
// Register-write scoreboard for x1..x31: one pending bit per register that
// has an in-flight writer between decode and writeback.
//   clk, rst_n            : clock, async active-low reset (clears all bits)
//   set_en / set_addr     : mark a register pending (issue with write-back)
//   clr_en / clr_addr     : retire a register (writeback)
//   rs1_addr / rs2_addr   : lookup addresses
//   rs1_pend / rs2_pend   : registered pending bit of each lookup (x0 -> 0)
// ---------------------------------------------------------------------------
module pipe_ctrl_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_addr,
  input  logic       clr_en,
  input  logic [4:0] clr_addr,
  input  logic [4:0] rs1_addr,
  input  logic [4:0] rs2_addr,
  output logic       rs1_pend,
  output logic       rs2_pend
);

  logic [31:1] pend_q;
  logic [31:1] pend_d;
  logic [31:0] pend_view;

  // The loop starts at 1 so x0 can never be set. When a new writer issues
  // to the same register that is retiring this cycle, the set term wins.
  always_comb begin
    pend_d = pend_q;
    for (int i = 1; i < 32; i++) begin
      pend_d[i] = (set_en && (set_addr == 5'(i))) ||
                  (pend_q[i] && !(clr_en && (clr_addr == 5'(i))));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Bit 0 of the view is a hard zero so x0 lookups never report pending.
  assign pend_view = {pend_q, 1'b0};
  assign rs1_pend  = pend_view[rs1_addr];
  assign rs2_pend  = pend_view[rs2_addr];

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Hazard and sequencing controller for the 5-stage RV32 core. Tracks
// in-flight register writes, stalls decode on read-after-write hazards and
// multi-cycle execute ops, squashes wrong-path fetches on a taken jump and
// flags a stall that never resolves.
//   MAX_STALL : consecutive stall cycles before deadlock_o sets (1..65535)
//   clk       : core clock
//   rst_n     : async active-low reset
//   bus       : pipe_ctrl_if.slave (decode/execute/writeback status in,
//               hold/flush/redirect/state/deadlock out)
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  pipe_ctrl_if.slave  bus
);

  ctrl_state_e            state_q, state_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   deadlock_q, deadlock_d;

  logic rs1_pend, rs2_pend;
  logic rs1_haz, rs2_haz, raw_haz;
  logic issue, set_en;

  logic hold_pc, hold_if_id, flush_if_id, flush_id_ex, jump_en;

  pipe_ctrl_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (set_en),
    .set_addr (bus.id_rd_addr_i),
    .clr_en   (bus.wb_wen_i),
    .clr_addr (bus.wb_rd_addr_i),
    .rs1_addr (bus.id_rs1_addr_i),
    .rs2_addr (bus.id_rs2_addr_i),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend)
  );

  // A writeback to the same register this cycle resolves the hazard because
  // the regfile is write-first.
  assign rs1_haz = bus.id_rs1_ren_i && rs1_pend && (bus.id_rs1_addr_i != ZERO_REG) &&
                   !(bus.wb_wen_i && (bus.wb_rd_addr_i == bus.id_rs1_addr_i));
  assign rs2_haz = bus.id_rs2_ren_i && rs2_pend && (bus.id_rs2_addr_i != ZERO_REG) &&
                   !(bus.wb_wen_i && (bus.wb_rd_addr_i == bus.id_rs2_addr_i));
  assign raw_haz = rs1_haz || rs2_haz;

  // A jump squashes the decode instruction, so it must not claim its rd.
  assign issue  = bus.id_valid_i && !hold_if_id && !bus.ex_jump_en_i;
  assign set_en = issue && bus.id_reg_wen_i;

  // Priority jump > busy > RAW. Busy does not bubble id_ex because execute
  // holds its own register; RAW inserts a bubble. All controls are forced
  // low while reset is asserted.
  always_comb begin
    state_d     = CTRL_RUN;
    hold_pc     = 1'b0;
    hold_if_id  = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jump_en     = 1'b0;
    if (rst_n) begin
      if (bus.ex_jump_en_i) begin
        state_d     = CTRL_FLUSH;
        jump_en     = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (bus.ex_busy_i) begin
        state_d    = CTRL_STALL_BUSY;
        hold_pc    = 1'b1;
        hold_if_id = 1'b1;
      end else if (raw_haz) begin
        state_d     = CTRL_STALL_RAW;
        hold_pc     = 1'b1;
        hold_if_id  = 1'b1;
        flush_id_ex = 1'b1;
      end
    end
  end

  // Count consecutive stall cycles (saturating); any RUN or FLUSH restarts
  // the count. The deadlock flag is sticky until reset.
  always_comb begin
    stall_cnt_d = '0;
    if (is_stall(state_d)) begin
      stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + 1'b1;
    end
    deadlock_d = deadlock_q || (stall_cnt_d >= STALL_CNT_W'(MAX_STALL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= CTRL_RUN;
      stall_cnt_q <= '0;
      deadlock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      deadlock_q  <= deadlock_d;
    end
  end

  assign bus.hold_pc_o     = hold_pc;
  assign bus.hold_if_id_o  = hold_if_id;
  assign bus.flush_if_id_o = flush_if_id;
  assign bus.flush_id_ex_o = flush_id_ex;
  assign bus.jump_en_o     = jump_en;
  assign bus.jump_addr_o   = bus.ex_jump_addr_i;
  assign bus.state_o       = state_q;
  assign bus.deadlock_o    = deadlock_q;

endmodule
